// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO level tracker.
// Pointer width is ceil_log2(DEPTH), at least one bit.
package fifo_pkg;

  localparam int AF_OFFSET = 1;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int ptr_width(input int depth);
    return (ceil_log2(depth) < 1) ? 1 : ceil_log2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH address register with increment enable.
// Wraps DEPTH-1 -> 0 so non-power-of-two depths never alias.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int W = ptr_width(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_ptr <= '0;
    else if (i_inc)
      r_ptr <= (r_ptr == W'(DEPTH - 1)) ? '0 : r_ptr + W'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_level_tracker.sv
// Occupancy, pointer and flag controller for a single-clock FIFO.
// Sticky overflow/underflow exist only with FIFO_LEVEL_TRACKER_ERR_EN.
module fifo_level_tracker
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - AF_OFFSET,
  parameter int AE_LEVEL = 1,
  localparam int PTR_W   = ptr_width(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  logic [CNT_W-1:0] r_level;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_full  = (r_level == CNT_W'(DEPTH));
  assign w_empty = (r_level == '0);

  // Qualified on registered level: a pop never makes room for a same-cycle push
  assign w_wr_en = push & ~w_full;
  assign w_rd_en = pop & ~w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_level <= '0;
    else if (w_wr_en & ~w_rd_en)
      r_level <= r_level + CNT_W'(1);
    else if (~w_wr_en & w_rd_en)
      r_level <= r_level - CNT_W'(1);
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_wr_en),
    .o_ptr (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_rd_en),
    .o_ptr (rd_ptr)
  );

  assign wr_en        = w_wr_en;
  assign rd_en        = w_rd_en;
  assign level        = r_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_level >= CNT_W'(AF_LEVEL));
  assign almost_empty = (r_level <= CNT_W'(AE_LEVEL));

`ifdef FIFO_LEVEL_TRACKER_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Set has priority over clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (push & w_full)      r_ovf <= 1'b1;
      else if (err_clr)       r_ovf <= 1'b0;
      if (pop & w_empty)      r_udf <= 1'b1;
      else if (err_clr)       r_udf <= 1'b0;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_udf;
`else
  logic w_unused;
  assign w_unused  = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
